// File: rtl/switch_port_stats.sv
// switch_port_stats: per-port ingress accept/drop and egress delivery counters
// for the N-port switch, with a live in-flight total, snapshot shadows and a
// registered read port. Counters either clamp at all-ones or wrap.
module switch_port_stats #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 32,
  parameter int SATURATE  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           ing_valid,
  input  logic [NUM_PORTS-1:0]           ing_full,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] ing_target,
  input  logic [NUM_PORTS-1:0]           egr_valid,
  input  logic                           clr,
  input  logic                           snap,
  input  logic                           rd_en,
  input  logic [$clog2(NUM_PORTS)-1:0]   rd_port,
  input  logic [1:0]                     rd_sel,
  output logic [CNT_W-1:0]               rd_data,
  output logic                           rd_valid,
  output logic [CNT_W-1:0]               inflight,
  output logic [NUM_PORTS-1:0]           sat_flag,
  output logic                           err_underflow
);

  localparam int IX_W = $clog2(NUM_PORTS);
  // Width of a popcount over one NUM_PORTS-bit mask.
  localparam int PW   = $clog2(NUM_PORTS + 1);
  // Width of the per-cycle accepted-weight sum over all ports.
  localparam int SW   = $clog2(NUM_PORTS * NUM_PORTS + 1);
  // Extended width for the in-flight arithmetic before resolving.
  localparam int EW   = CNT_W + SW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Live counters
  cnt_t acc_q   [NUM_PORTS];
  cnt_t acc_d   [NUM_PORTS];
  cnt_t drop_q  [NUM_PORTS];
  cnt_t drop_d  [NUM_PORTS];
  cnt_t deliv_q [NUM_PORTS];
  cnt_t deliv_d [NUM_PORTS];
  cnt_t inflight_q, inflight_d;
  logic [NUM_PORTS-1:0] sat_flag_q, sat_flag_d;
  logic err_underflow_q, err_underflow_d;

  // Snapshot shadows
  cnt_t sh_acc_q   [NUM_PORTS];
  cnt_t sh_acc_d   [NUM_PORTS];
  cnt_t sh_drop_q  [NUM_PORTS];
  cnt_t sh_drop_d  [NUM_PORTS];
  cnt_t sh_deliv_q [NUM_PORTS];
  cnt_t sh_deliv_d [NUM_PORTS];
  cnt_t sh_inflight_q, sh_inflight_d;

  // Read port
  cnt_t rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;

  function automatic logic [PW-1:0] popcnt(input logic [NUM_PORTS-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_PORTS; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  // Adds inc to cnt; bit CNT_W of the result flags saturation (clamp mode)
  // or wrap-around (wrap mode), the low CNT_W bits are the new count.
  function automatic logic [CNT_W:0] bump(input cnt_t cnt, input logic [PW-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W + 1 - PW){1'b0}}, inc};
    if (SATURATE != 0) begin
      if (inc != '0 && sum >= {1'b0, CNT_MAX}) return {1'b1, CNT_MAX};
      return {1'b0, sum[CNT_W-1:0]};
    end
    return sum;
  endfunction

  // Live counter, in-flight and sticky-flag next state; clr overrides all events.
  always_comb begin : live_next
    logic [PW-1:0]    w;
    logic [CNT_W:0]   r;
    logic [SW-1:0]    acc_sum;
    logic [PW-1:0]    egr_cnt;
    logic [EW-1:0]    pos;
    logic [EW-1:0]    diff;
    // NOTE: every comb output gets a default first so no path can infer a latch.
    acc_d           = acc_q;
    drop_d          = drop_q;
    deliv_d         = deliv_q;
    inflight_d      = inflight_q;
    sat_flag_d      = sat_flag_q;
    err_underflow_d = err_underflow_q;
    w       = '0;
    r       = '0;
    acc_sum = '0;
    diff    = '0;

    for (int p = 0; p < NUM_PORTS; p++) begin
      w = popcnt(ing_target[p*NUM_PORTS +: NUM_PORTS]);
      if (ing_valid[p]) begin
        if (ing_full[p]) begin
          r         = bump(drop_q[p], w);
          drop_d[p] = r[CNT_W-1:0];
        end else begin
          r         = bump(acc_q[p], w);
          acc_d[p]  = r[CNT_W-1:0];
          acc_sum   = acc_sum + SW'(w);
        end
        sat_flag_d[p] = sat_flag_d[p] | r[CNT_W];
      end
      if (egr_valid[p]) begin
        r             = bump(deliv_q[p], PW'(1));
        deliv_d[p]    = r[CNT_W-1:0];
        sat_flag_d[p] = sat_flag_d[p] | r[CNT_W];
      end
    end

    // In-flight total is resolved in a wider domain so that neither the
    // negative nor the overflow case is lost before clamping.
    egr_cnt = popcnt(egr_valid);
    pos     = EW'(inflight_q) + EW'(acc_sum);
    if (pos < EW'(egr_cnt)) begin
      inflight_d      = '0;
      err_underflow_d = 1'b1;
    end else begin
      diff = pos - EW'(egr_cnt);
      if (diff > EW'(CNT_MAX) && SATURATE != 0) inflight_d = CNT_MAX;
      else                                      inflight_d = diff[CNT_W-1:0];
    end

    if (clr) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        acc_d[p]   = '0;
        drop_d[p]  = '0;
        deliv_d[p] = '0;
      end
      inflight_d      = '0;
      sat_flag_d      = '0;
      err_underflow_d = 1'b0;
    end
  end

  // Shadows capture the pre-update live values on snap and are untouched by clr.
  always_comb begin
    sh_acc_d      = sh_acc_q;
    sh_drop_d     = sh_drop_q;
    sh_deliv_d    = sh_deliv_q;
    sh_inflight_d = sh_inflight_q;
    if (snap) begin
      sh_acc_d      = acc_q;
      sh_drop_d     = drop_q;
      sh_deliv_d    = deliv_q;
      sh_inflight_d = inflight_q;
    end
  end

  // Read mux over the current shadow contents; data holds when no read is issued.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      if (rd_sel == 2'd3) begin
        rd_data_d = sh_inflight_q;
      end else if ({1'b0, rd_port} >= (IX_W + 1)'(NUM_PORTS)) begin
        rd_data_d = '0;
      end else begin
        case (rd_sel)
          2'd0:    rd_data_d = sh_acc_q[rd_port];
          2'd1:    rd_data_d = sh_drop_q[rd_port];
          default: rd_data_d = sh_deliv_q[rd_port];
        endcase
      end
    end
  end

  // State registers; asynchronous reset clears every counter, shadow and output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter and shadow arrays are reset explicitly because their
      // contents are architecturally visible right after reset.
      for (int p = 0; p < NUM_PORTS; p++) begin
        acc_q[p]      <= '0;
        drop_q[p]     <= '0;
        deliv_q[p]    <= '0;
        sh_acc_q[p]   <= '0;
        sh_drop_q[p]  <= '0;
        sh_deliv_q[p] <= '0;
      end
      inflight_q      <= '0;
      sat_flag_q      <= '0;
      err_underflow_q <= 1'b0;
      sh_inflight_q   <= '0;
      rd_data_q       <= '0;
      rd_valid_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      acc_q           <= acc_d;
      drop_q          <= drop_d;
      deliv_q         <= deliv_d;
      inflight_q      <= inflight_d;
      sat_flag_q      <= sat_flag_d;
      err_underflow_q <= err_underflow_d;
      sh_acc_q        <= sh_acc_d;
      sh_drop_q       <= sh_drop_d;
      sh_deliv_q      <= sh_deliv_d;
      sh_inflight_q   <= sh_inflight_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign inflight      = inflight_q;
  assign sat_flag      = sat_flag_q;
  assign err_underflow = err_underflow_q;

endmodule
